window_writer: RTL



---
 rtl/window_writer_pkg.sv | 26 ++
 rtl/window_writer_addr_gen.sv | 74 +++++++
 rtl/window_writer.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/window_writer_pkg.sv
// Shared definitions for the window reader/writer pair and the image Memory.
// Holds the RW bus encoding, the writer FSM states and the address mapping.
package window_writer_pkg;

    localparam logic [1:0] RW_IDLE  = 2'b00;
    localparam logic [1:0] RW_READ  = 2'b01;
    localparam logic [1:0] RW_WRITE = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_NEXT,
        ST_DONE
    } wr_state_e;

    // Row-major pixel address; callers truncate to their bus width.
    function automatic int unsigned win_addr(
        input int unsigned row,
        input int unsigned col,
        input int unsigned width
    );
        return row * width + col;
    endfunction

endpackage

// File: rtl/window_writer_addr_gen.sv
// Window row/column walker and pixel address generator.
// Exposes the address and element index of the *next* counter state.
module window_addr_gen
    import window_writer_pkg::*;
#(
    parameter int WINDOW_SIZE = 3,
    parameter int IMG_WIDTH   = 7,
    parameter int BUS_WIDTH   = 8,
    parameter int KW          = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [BUS_WIDTH-1:0] rstrt_i,
    input  logic [BUS_WIDTH-1:0] cstrt_i,
    input  logic                 adv_i,
    output logic [BUS_WIDTH-1:0] addr_o,
    output logic [KW-1:0]        idx_o,
    output logic                 last_o
);

    localparam int CW = (WINDOW_SIZE > 1) ? $clog2(WINDOW_SIZE) : 1;
    localparam logic [CW-1:0] EDGE = CW'(WINDOW_SIZE - 1);

    logic [BUS_WIDTH-1:0] rs_q, rs_d;
    logic [BUS_WIDTH-1:0] cs_q, cs_d;
    logic [CW-1:0]        r_q, r_d;
    logic [CW-1:0]        c_q, c_d;

    // Next-state: load the window origin, or step row-major.
    always_comb begin
        rs_d = rs_q;
        cs_d = cs_q;
        r_d  = r_q;
        c_d  = c_q;
        if (load_i) begin
            rs_d = rstrt_i;
            cs_d = cstrt_i;
            r_d  = '0;
            c_d  = '0;
        end else if (adv_i) begin
            if (c_q == EDGE) begin
                c_d = '0;
                r_d = r_q + CW'(1);
            end else begin
                c_d = c_q + CW'(1);
            end
        end
    end

    // Origin and counter registers; reset abandons any walk in progress.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rs_q <= '0;
            cs_q <= '0;
            r_q  <= '0;
            c_q  <= '0;
        end else begin
            rs_q <= rs_d;
            cs_q <= cs_d;
            r_q  <= r_d;
            c_q  <= c_d;
        end
    end

    // Wide product truncated to the bus: only the low address bits matter.
    assign addr_o = BUS_WIDTH'(win_addr(32'(rs_d) + 32'(r_d),
                                        32'(cs_d) + 32'(c_d),
                                        IMG_WIDTH));

    assign idx_o  = KW'(32'(r_d) * 32'(WINDOW_SIZE) + 32'(c_d));
    assign last_o = (r_q == EDGE) && (c_q == EDGE);

endmodule

// File: rtl/window_writer.sv
// Writes one packed WINDOW_SIZE^2 pixel block back to the image Memory.
// Optional WAIT abort on missing DRDY: define WINDOW_WRITER_TIMEOUT_EN.
module window_writer
    import window_writer_pkg::*;
#(
    parameter int WINDOW_SIZE = 3,
    parameter int IMG_WIDTH   = 7,
    parameter int IMG_HEIGHT  = 7,
    parameter int BUS_WIDTH   = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int TIMEOUT     = 15
) (
    input  logic                                      Wrt_CLK,
    input  logic                                      Wrt_RST,
    input  logic [BUS_WIDTH-1:0]                      Wrt_Rstrt,
    input  logic [BUS_WIDTH-1:0]                      Wrt_Cstrt,
    input  logic                                      Wrt_En,
    input  logic [DATA_WIDTH*WINDOW_SIZE*WINDOW_SIZE-1:0] Wrt_Data,
    input  logic                                      Wrt_DRDY,
    output logic [BUS_WIDTH-1:0]                      Wrt_MemAddr,
    output logic [DATA_WIDTH-1:0]                     Wrt_MemData,
    output logic [1:0]                                Wrt_Wen,
    output logic                                      Wrt_RDY,
    output logic                                      Wrt_ERR
);

    localparam int NELEM = WINDOW_SIZE * WINDOW_SIZE;
    localparam int KW    = (NELEM > 1) ? $clog2(NELEM) : 1;
    localparam int PW    = DATA_WIDTH * NELEM;

    wr_state_e            state_q;
    logic [PW-1:0]        data_q;
    logic [BUS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] mdata_q;
    logic [1:0]           wen_q;
    logic                 rdy_q;
    logic                 err_q;

    logic                 load;
    logic                 adv;
    logic                 last;
    logic                 oob;
    logic [BUS_WIDTH-1:0] addr_nxt;
    logic [KW-1:0]        idx_nxt;
    logic [PW-1:0]        data_src;
    logic [DATA_WIDTH-1:0] elem;

`ifdef WINDOW_WRITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
    logic [TW-1:0] tmo_q;
`endif

    assign load = (state_q == ST_IDLE) && Wrt_En;
    assign adv  = (state_q == ST_NEXT) && !last;

    assign oob = (32'(Wrt_Rstrt) + 32'(WINDOW_SIZE) > 32'(IMG_HEIGHT)) ||
                 (32'(Wrt_Cstrt) + 32'(WINDOW_SIZE) > 32'(IMG_WIDTH));

    window_addr_gen #(
        .WINDOW_SIZE (WINDOW_SIZE),
        .IMG_WIDTH   (IMG_WIDTH),
        .BUS_WIDTH   (BUS_WIDTH),
        .KW          (KW)
    ) u_addr (
        .clk_i   (Wrt_CLK),
        .rst_i   (Wrt_RST),
        .load_i  (load),
        .rstrt_i (Wrt_Rstrt),
        .cstrt_i (Wrt_Cstrt),
        .adv_i   (adv),
        .addr_o  (addr_nxt),
        .idx_o   (idx_nxt),
        .last_o  (last)
    );

    // The first element comes straight off the input; later ones from the latch.
    assign data_src = (state_q == ST_IDLE) ? Wrt_Data : data_q;

    // Select the next element to be written from the packed window.
    always_comb begin
        elem = '0;
        for (int k = 0; k < NELEM; k++) begin
            if (idx_nxt == KW'(k)) begin
                elem = data_src[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Write sequencer with registered Memory-side outputs and status flags.
    always_ff @(posedge Wrt_CLK) begin
        if (Wrt_RST) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            addr_q  <= '0;
            mdata_q <= '0;
            wen_q   <= RW_IDLE;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
`ifdef WINDOW_WRITER_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (Wrt_En) begin
                        data_q <= Wrt_Data;
                        if (oob) begin
                            state_q <= ST_DONE;
                            err_q   <= 1'b1;
                        end else begin
                            state_q <= ST_ISSUE;
                            wen_q   <= RW_WRITE;
                            addr_q  <= addr_nxt;
                            mdata_q <= elem;
                        end
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_WAIT;
`ifdef WINDOW_WRITER_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                ST_WAIT: begin
                    if (Wrt_DRDY) begin
                        state_q <= ST_NEXT;
                        wen_q   <= RW_IDLE;
                    end
`ifdef WINDOW_WRITER_TIMEOUT_EN
                    else if (tmo_q == TMO_LAST) begin
                        state_q <= ST_DONE;
                        wen_q   <= RW_IDLE;
                        err_q   <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
`endif
                end
                ST_NEXT: begin
                    if (last) begin
                        state_q <= ST_DONE;
                        rdy_q   <= 1'b1;
                    end else begin
                        state_q <= ST_ISSUE;
                        wen_q   <= RW_WRITE;
                        addr_q  <= addr_nxt;
                        mdata_q <= elem;
                    end
                end
                ST_DONE: begin
                    if (!Wrt_En) begin
                        state_q <= ST_IDLE;
                        rdy_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Wrt_MemAddr = addr_q;
    assign Wrt_MemData = mdata_q;
    assign Wrt_Wen     = wen_q;
    assign Wrt_RDY     = rdy_q;
    assign Wrt_ERR     = err_q;

endmodule
